// File: rtl/csw_tape_player.sv
// csw_tape_player: plays a CSW v1 run-length pulse image into the cassette
// read line. Lengths arrive as bytes (0x00 escapes a 32-bit little-endian
// length), are staged in a one-entry prefetch register and counted down in
// CSW sample ticks derived from clk_sys by a fractional accumulator.
// Optional feature macro: CSW_UNDERRUN_CNT_EN adds underrun_cnt[7:0].
module csw_tape_player #(
  parameter int CLK_HZ = 64000000,
  parameter int LEN_W  = 32
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        start,
  input  logic        init_level,
  input  logic [23:0] sample_rate,
  input  logic        motor,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_last,
  output logic        din_ready,
  output logic        tape_out,
  output logic        playing,
  output logic        done,
  output logic        underrun,
  output logic [2:0]  dbg_state
`ifdef CSW_UNDERRUN_CNT_EN
  , output logic [7:0] underrun_cnt
`endif
);

  // Handshake: a byte moves when din_valid and din_ready are both high at a
  // rising clk_sys edge; din and din_last are only meaningful while din_valid
  // is high, and din_ready never depends on din_valid.

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXT0  = 3'd2;
  localparam logic [2:0] ST_EXT1  = 3'd3;
  localparam logic [2:0] ST_EXT2  = 3'd4;
  localparam logic [2:0] ST_EXT3  = 3'd5;

  localparam logic [32:0] CLK_MOD = 33'(CLK_HZ);

  logic [2:0]       state;
  logic [23:0]      ext_buf;
  logic             eos;
  logic [LEN_W-1:0] pf_len;
  logic             pf_full;
  logic [LEN_W-1:0] cur_len;
  logic             cur_valid;
  logic [31:0]      acc;

  logic             in_ext;
  logic             xfer;
  logic             fill;
  logic             fill_ext;
  logic [31:0]      ext_len;
  logic [LEN_W-1:0] fill_len;
  logic             tick_en;
  logic [32:0]      acc_sum;
  logic [32:0]      acc_wrap;
  logic             tick;
  logic             expire;
  logic             take;
  logic             underrun_cond;
  logic             end_cond;

  assign dbg_state = state;

  // Decoder handshake, prefetch fill and tick/expiry decode.
  always_comb begin
    in_ext    = (state >= ST_EXT0) && (state <= ST_EXT3);
    // A start cycle accepts nothing, so no byte is lost to the restart.
    din_ready = !start && (((state == ST_FETCH) && !pf_full) || in_ext);
    xfer      = din_valid && din_ready;
    fill_ext  = xfer && (state == ST_EXT3);
    fill      = fill_ext || (xfer && (state == ST_FETCH) && (din != 8'd0));
    ext_len   = {din, ext_buf};
    if (ext_len == 32'd0) ext_len = 32'd1;
    fill_len  = fill_ext ? LEN_W'(ext_len) : LEN_W'(din);
    tick_en   = playing && motor && cur_valid && (sample_rate != 24'd0);
    acc_sum   = {1'b0, acc} + {9'd0, sample_rate};
    acc_wrap  = acc_sum - CLK_MOD;
    tick      = tick_en && (acc_sum >= CLK_MOD);
    expire    = tick && (cur_len == LEN_W'(1));
    // Reload when idle, or seamlessly on the tick that ends the pulse.
    take      = pf_full && (!cur_valid || expire);
    // A length completing or a final byte arriving this cycle is not a starve.
    underrun_cond = expire && !pf_full && !eos && !fill && !(xfer && din_last);
    end_cond  = playing && eos && (state == ST_IDLE) && !pf_full && !cur_valid;
  end

  // Byte-stream decoder: plain lengths, 0x00 escape and end-of-stream flag.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      ext_buf <= 24'd0;
      eos     <= 1'b0;
    end else if (start) begin
      state   <= ST_FETCH;
      ext_buf <= 24'd0;
      eos     <= 1'b0;
    end else if (xfer) begin
      case (state)
        ST_FETCH: if (din == 8'd0) state <= ST_EXT0;
        ST_EXT0: begin ext_buf[7:0]   <= din; state <= ST_EXT1; end
        ST_EXT1: begin ext_buf[15:8]  <= din; state <= ST_EXT2; end
        ST_EXT2: begin ext_buf[23:16] <= din; state <= ST_EXT3; end
        ST_EXT3: state <= ST_FETCH;
        default: state <= ST_IDLE;
      endcase
      // The last byte ends the image; any partial escape length is dropped.
      if (din_last) begin
        eos   <= 1'b1;
        state <= ST_IDLE;
      end
    end
  end

  // One-entry prefetch: a fill in the same cycle as a reload refills the slot.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      pf_len  <= '0;
      pf_full <= 1'b0;
    end else if (start) begin
      pf_len  <= '0;
      pf_full <= 1'b0;
    end else if (fill) begin
      pf_len  <= fill_len;
      pf_full <= 1'b1;
    end else if (take) begin
      pf_full <= 1'b0;
    end
  end

  // Player: tick accumulator, pulse countdown, level toggle and status flags.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      acc       <= 32'd0;
      cur_len   <= '0;
      cur_valid <= 1'b0;
      tape_out  <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else if (start) begin
      acc       <= 32'd0;
      cur_len   <= '0;
      cur_valid <= 1'b0;
      tape_out  <= init_level;
      playing   <= 1'b1;
      done      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= underrun_cond;
      if (tick_en) acc <= tick ? acc_wrap[31:0] : acc_sum[31:0];
      if (take) begin
        cur_len   <= pf_len;
        cur_valid <= 1'b1;
      end else if (expire) begin
        cur_valid <= 1'b0;
      end else if (tick) begin
        cur_len <= cur_len - LEN_W'(1);
      end
      if (expire) tape_out <= ~tape_out;
      if (end_cond) begin
        playing <= 1'b0;
        done    <= 1'b1;
      end
    end
  end

`ifdef CSW_UNDERRUN_CNT_EN
  // Saturating count of underrun events since reset or start.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      underrun_cnt <= 8'd0;
    end else if (start) begin
      underrun_cnt <= 8'd0;
    end else if (underrun_cond && (underrun_cnt != 8'hFF)) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_csw_tape_player.sv
// Bench for csw_tape_player with CLK_HZ=100 and sample_rate=10, so one CSW
// sample is exactly 10 clocks. Expected events (tape edges, underrun pulses,
// done rising) are stamped with their clock offset from the last start edge.
module tb_csw_tape_player;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        start;
  logic        init_level;
  logic [23:0] sample_rate;
  logic        motor;
  logic [7:0]  din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic        tape_out;
  logic        playing;
  logic        done;
  logic        underrun;
  logic [2:0]  dbg_state;
`ifdef CSW_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  csw_tape_player #(.CLK_HZ(100), .LEN_W(32)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .start       (start),
    .init_level  (init_level),
    .sample_rate (sample_rate),
    .motor       (motor),
    .din         (din),
    .din_valid   (din_valid),
    .din_last    (din_last),
    .din_ready   (din_ready),
    .tape_out    (tape_out),
    .playing     (playing),
    .done        (done),
    .underrun    (underrun),
    .dbg_state   (dbg_state)
`ifdef CSW_UNDERRUN_CNT_EN
    , .underrun_cnt (underrun_cnt)
`endif
  );

  // Clock and cycle counter.
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  int start_cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Scoreboard: {kind[1:0], value, offset[28:0]}; kind 0=edge 1=underrun 2=done.
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic prev_tape = 1'b0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic val, input int off);
    exp_q.push_back({kind, val, 29'(off)});
  endtask

  task automatic got_event(input logic [1:0] kind, input logic val);
    logic [31:0] act;
    logic [31:0] e;
    act = {kind, val, 29'(cyc - start_cyc)};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d val %0d off %0d expected none",
               kind, val, cyc - start_cyc);
    end else begin
      e = exp_q.pop_front();
      if (e !== act) begin
        n_fail++;
        $display("FAIL event: got kind %0d val %0d off %0d expected kind %0d val %0d off %0d",
                 act[31:30], act[29], act[28:0], e[31:30], e[29], e[28:0]);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and scores them.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (tape_out !== prev_tape) got_event(2'd0, tape_out);
        if (underrun) got_event(2'd1, 1'b1);
        if (done && !prev_done) got_event(2'd2, 1'b1);
      end
      prev_tape = tape_out;
      prev_done = done;
    end
  end

  // Driver tasks; each returns 1 time unit after a rising edge.
  task automatic do_start(input logic lvl);
    init_level = lvl;
    start = 1'b1;
    @(posedge clk_sys); #1;
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    logic r;
    int n;
    n = 0;
    r = 1'b0;
    din = b;
    din_last = last;
    din_valid = 1'b1;
    while (!r && n < 200) begin
      @(negedge clk_sys);
      r = din_ready;
      @(posedge clk_sys); #1;
      n++;
    end
    din_valid = 1'b0;
    din_last = 1'b0;
    if (!r) check("send_timeout", 32'(r), 32'd1);
  endtask

  task automatic wait_to(input int off);
    while (cyc - start_cyc < off) begin
      @(posedge clk_sys); #1;
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("done_timeout", 32'(done), 32'd1);
    repeat (2) begin
      @(posedge clk_sys); #1;
    end
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    init_level = 1'b0;
    sample_rate = 24'd10;
    motor = 1'b1;
    din = 8'd0;
    din_valid = 1'b0;
    din_last = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_tape", 32'(tape_out), 32'd0);
    check("rst_playing", 32'(playing), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(din_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // Basic pulses 3, 2: load at 2, rise 32, fall 52, done 53.
    push_exp(2'd0, 1'b1, 32);
    push_exp(2'd0, 1'b0, 52);
    push_exp(2'd2, 1'b1, 53);
    do_start(1'b0);
    check("start_playing", 32'(playing), 32'd1);
    send_byte(8'd3, 1'b0);
    send_byte(8'd2, 1'b1);
    wait_done(200);
    check("basic_playing", 32'(playing), 32'd0);
    check("basic_tape", 32'(tape_out), 32'd0);

    // Extended length 5: load at 6, rise 56, done 57.
    push_exp(2'd0, 1'b1, 56);
    push_exp(2'd2, 1'b1, 57);
    do_start(1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_done(200);

    // Extended zero length coerced to 1: fall at start, rise 16, done 17.
    push_exp(2'd0, 1'b0, 0);
    push_exp(2'd0, 1'b1, 16);
    push_exp(2'd2, 1'b1, 17);
    do_start(1'b0);
    for (int i = 0; i < 5; i++) send_byte(8'h00, i == 4);
    wait_done(200);

    // Motor gating: lengths 1, 4; motor off for edges 25..61 stretches fall to 89.
    push_exp(2'd0, 1'b0, 0);
    push_exp(2'd0, 1'b1, 12);
    push_exp(2'd0, 1'b0, 89);
    push_exp(2'd2, 1'b1, 90);
    do_start(1'b0);
    send_byte(8'd1, 1'b0);
    send_byte(8'd4, 1'b1);
    wait_to(24);
    motor = 1'b0;
    wait_to(61);
    check("motor_mid_tape", 32'(tape_out), 32'd1);
    motor = 1'b1;
    wait_done(300);

    // Underrun: 2 then starve; underrun with the rise at 22; 4 arrives at 41.
    push_exp(2'd0, 1'b1, 22);
    push_exp(2'd1, 1'b1, 22);
    push_exp(2'd0, 1'b0, 82);
    push_exp(2'd2, 1'b1, 83);
    do_start(1'b0);
    send_byte(8'd2, 1'b0);
    wait_to(30);
    check("underrun_playing", 32'(playing), 32'd1);
    check("underrun_tape", 32'(tape_out), 32'd1);
`ifdef CSW_UNDERRUN_CNT_EN
    check("underrun_cnt", 32'(underrun_cnt), 32'd1);
`endif
    wait_to(40);
    send_byte(8'd4, 1'b1);
    wait_done(200);

    // Reset mid-pulse, then a 1-sample pulse starting high.
    push_exp(2'd0, 1'b1, 0);
    do_start(1'b1);
    send_byte(8'd5, 1'b1);
    wait_to(20);
    #1;
    reset = 1'b1;
    #1;
    check("arst_tape", 32'(tape_out), 32'd0);
    check("arst_playing", 32'(playing), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_ready", 32'(din_ready), 32'd0);
    check("arst_queue", 32'(exp_q.size()), 32'd0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (2) begin
      @(posedge clk_sys); #1;
    end
    push_exp(2'd0, 1'b1, 0);
    push_exp(2'd0, 1'b0, 12);
    push_exp(2'd2, 1'b1, 13);
    do_start(1'b1);
    send_byte(8'd1, 1'b1);
    wait_done(200);

    // Restart mid-pulse: old prefetch (2) dropped, new stream 1 plays.
    do_start(1'b0);
    send_byte(8'd3, 1'b0);
    send_byte(8'd2, 1'b1);
    wait_to(10);
    push_exp(2'd0, 1'b1, 0);
    push_exp(2'd0, 1'b0, 12);
    push_exp(2'd2, 1'b1, 13);
    do_start(1'b1);
    check("restart_tape", 32'(tape_out), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    send_byte(8'd1, 1'b1);
    wait_done(200);
    check("restart_end_tape", 32'(tape_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csw_tape_player.md
Name: csw_tape_player

Overview:
- Plays a CSW v1 (RLE pulse-length) cassette image into the motherboard tape input.
- Sits upstream of the motherboard cassette-read line. Consumes a byte stream from the file loader through a valid/ready handshake.
- Converts sample-count pulse lengths to clk_sys time with a fractional accumulator.
- Playback advances only while the cassette motor (PPI port C motor bit) is on.

Parameters:
CLK_HZ, 64000000, clk_sys frequency in Hz; accumulator modulus.
LEN_W, 32, width of pulse-length registers.

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begin/restart playback
init_level  in  1  tape_out level loaded on start
sample_rate  in  24  CSW sample rate in Hz; 0 = no ticks
motor  in  1  cassette motor; 0 freezes playback timing
din  in  8  stream byte
din_valid  in  1  din valid
din_last  in  1  qualifies din as final byte of image
din_ready  out  1  block accepts din this cycle
tape_out  out  1  cassette read level to motherboard
playing  out  1  playback active
done  out  1  sticky end-of-stream flag
underrun  out  1  one-cycle pulse; pulse expired with no next length

Behaviour:
- Single clock domain.
- Reset is asynchronous and active-high.
- Reset clears all outputs, acc, state and flags to 0; the decoder returns to IDLE.
- Start:
  - tape_out<=init_level, playing<=1, done<=0.
  - Clears acc, the prefetch register, cur_valid and the eos flag; decoder goes to FETCH.
  - Start while playing is a full restart.
- Decoder states: IDLE, FETCH, EXT0..EXT3.
  - din_ready=1 only in FETCH with prefetch empty, or in EXT0..3.
  - Transfer = din_valid & din_ready.
  - FETCH, byte!=0: prefetch<=byte (zero-extended); prefetch becomes full.
  - FETCH, byte==0: go to EXT0.
  - EXT0..3 collect a little-endian 32-bit length. After EXT3 the length goes to prefetch; length 0 is coerced to 1.
  - din_last on any transfer sets eos; the decoder goes to IDLE after that byte.
  - If din_last arrives in FETCH on a 0 byte or in EXT0..2, the partial length is discarded.
- Player:
  - cur_len and cur_valid hold the active pulse.
  - When cur_valid=0 and prefetch is full, load cur_len from prefetch and empty prefetch in the same cycle.
- Tick generation:
  - Enabled when playing & motor & cur_valid & sample_rate!=0.
  - Each enabled cycle: if acc+sample_rate>=CLK_HZ then acc<=acc+sample_rate-CLK_HZ and tick; else acc<=acc+sample_rate.
  - acc is 32 bits; it is frozen while not enabled.
- On tick:
  - If cur_len==1: toggle tape_out. If prefetch is full, reload cur_len from it in the same cycle (seamless). Otherwise cur_valid<=0.
  - Else cur_len<=cur_len-1.
- Underrun: a pulse expires with prefetch empty, eos=0 and the decoder not finishing a length. Raise underrun for one cycle; playing stays 1; ticks stop until the next length loads.
- End: when eos=1, the decoder is IDLE, prefetch is empty and cur_valid=0, set playing<=0 and done<=1. tape_out holds its last level.
- Motor=0: timing frozen; decoder still fills prefetch.
- Simultaneous prefetch fill and reload in one cycle: the reload takes the old prefetch; the incoming byte fills the freed slot.

Optional Feature:
- Macro: CSW_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt[7:0], a saturating count of underrun pulses at 255.
  - Cleared by reset and by start.
- Undefined: the port is absent; the underrun pulse is unchanged.

Test Plan:
- Basic pulses. Setup: CLK_HZ=100, sample_rate=10, init_level=0, motor=1, bytes 3, 2(last). Required:
  - tape_out rises 30 clocks after the first length loads, falls 20 clocks later.
  - done=1 and playing=0 after the fall; tape_out ends 0.
- Extended length. Same setup, bytes 00,05,00,00,00(last). Required: one pulse of 50 clocks; extended bytes 00 00 00 00 give a 10-clock pulse (coerced to 1).
- Motor gating. Drop motor for 37 clocks mid-pulse during length 4. Required: high time = 40+37 clocks; acc resumes with no lost or extra tick.
- Underrun. Send 2 and withhold data. Required:
  - underrun pulses exactly once at expiry; tape_out has toggled once; playing=1.
  - Then send 4(last): the next toggle comes 40 clocks after the load; done follows.
- Reset mid-pulse. Required: all outputs 0 asynchronously. A subsequent start with init_level=1 and bytes 1(last) gives tape_out 1 then 0 after 10 clocks.
- Restart. Pulse start during an active pulse. Required: tape_out=init_level next cycle; the old prefetch is discarded; the new stream plays from its first byte.
